// File: rtl/lexicode_search_ctrl.sv
// Greedy lexicode search sequencer: seeds a candidate bank, emits the lowest survivor,
// and ping-pongs the hamming-distance filter between two banks of the shared candidate RAM.
module lexicode_search_ctrl #(
  parameter int         N          = 5,
  parameter int         START_HOLD = 4,
  parameter logic [7:0] BANK1_BASE = 8'h80
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] min_dist,
  input  logic [7:0] max_codes,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] code_count,
  output logic [7:0] code_out,
  output logic       code_valid,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_wren,
  input  logic [7:0] ram_q,
  output logic       filt_start,
  input  logic       filt_complete,
  output logic [7:0] filt_code,
  output logic [7:0] filt_src_base,
  output logic [7:0] filt_dst_base,
  output logic [7:0] filt_len,
  output logic [3:0] filt_min_dist,
  input  logic [7:0] filt_next_len,
  input  logic [7:0] filt_addr,
  input  logic [7:0] filt_data,
  input  logic       filt_wren
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_CHECK, S_RD0, S_RD1, S_RD2,
    S_EMIT, S_FSTART, S_FWAIT, S_SWAP, S_DONE
  } state_t;

  localparam logic [7:0] WORDS = 8'(1 << N);
  localparam logic [7:0] HOLD  = 8'(START_HOLD);

  function automatic logic [7:0] bank_base(input logic sel);
    return sel ? BANK1_BASE : 8'h00;
  endfunction

  state_t     state;
  logic [7:0] idx;
  logic [7:0] len;
  logic       cur;
  logic [7:0] hold_cnt;
  logic [3:0] min_dist_q;
  logic [7:0] max_codes_q;
  logic [7:0] ram_addr_q;
  logic [7:0] ram_data_q;
  logic       ram_wren_q;
  logic       filt_owns;

  // The filter owns the RAM port while it is being started and while it runs
  assign filt_owns = (state == S_FSTART) || (state == S_FWAIT);
  assign ram_addr  = filt_owns ? filt_addr : ram_addr_q;
  assign ram_data  = filt_owns ? filt_data : ram_data_q;
  assign ram_wren  = filt_owns ? filt_wren : ram_wren_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      len           <= '0;
      cur           <= 1'b0;
      hold_cnt      <= '0;
      min_dist_q    <= '0;
      max_codes_q   <= '0;
      ram_addr_q    <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      code_count    <= '0;
      code_out      <= '0;
      code_valid    <= 1'b0;
      filt_start    <= 1'b0;
      filt_code     <= '0;
      filt_src_base <= '0;
      filt_dst_base <= '0;
      filt_len      <= '0;
      filt_min_dist <= '0;
    end else begin
      done       <= 1'b0;
      code_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            min_dist_q  <= min_dist;
            max_codes_q <= max_codes;
            code_count  <= '0;
            err         <= 1'b0;
            if (min_dist == 4'd0) begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              // Word 0 is presented on the accepting edge so the first write lands next cycle
              busy       <= 1'b1;
              cur        <= 1'b0;
              idx        <= 8'd1;
              ram_addr_q <= 8'd0;
              ram_data_q <= 8'd0;
              ram_wren_q <= 1'b1;
              state      <= S_INIT;
            end
          end
        end
        S_INIT: begin
          if (idx == WORDS) begin
            ram_wren_q <= 1'b0;
            len        <= WORDS;
            state      <= S_CHECK;
          end else begin
            ram_addr_q <= idx;
            ram_data_q <= idx;
            idx        <= idx + 8'd1;
          end
        end
        S_CHECK: begin
          if (len == 8'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            ram_addr_q <= bank_base(cur);
            state      <= S_RD0;
          end
        end
        S_RD0: state <= S_RD1;
        S_RD1: state <= S_RD2;
        S_RD2: begin
          code_out   <= ram_q;
          code_valid <= 1'b1;
          code_count <= code_count + 8'd1;
          state      <= S_EMIT;
        end
        S_EMIT: begin
          if (max_codes_q != 8'd0 && code_count == max_codes_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            filt_code     <= code_out;
            filt_src_base <= bank_base(cur);
            filt_dst_base <= bank_base(~cur);
            filt_len      <= len;
            filt_min_dist <= min_dist_q;
            filt_start    <= 1'b1;
            hold_cnt      <= 8'd1;
            state         <= S_FSTART;
          end
        end
        S_FSTART: begin
          if (hold_cnt >= HOLD) begin
            filt_start <= 1'b0;
            state      <= S_FWAIT;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        S_FWAIT: begin
          if (filt_complete) begin
            len   <= filt_next_len;
            state <= S_SWAP;
          end
        end
        S_SWAP: begin
          cur   <= ~cur;
          state <= S_CHECK;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lexicode_search_ctrl.sv
// Bench for lexicode_search_ctrl: RAM and filter models around an N=5 and an N=4 instance,
// results compared with a direct greedy lexicode computation.
module tb_lexicode_search_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start5 = 1'b0, start4 = 1'b0;
  logic [3:0] min_dist = '0;
  logic [7:0] max_codes = '0;
  logic [7:0] ram_q;
  logic       filt_complete;
  logic [7:0] filt_next_len, filt_addr, filt_data;
  logic       filt_wren;
  logic       sel = 1'b0;

  logic       busy5, done5, err5, code_valid5, ram_wren5, filt_start5;
  logic [7:0] code_count5, code_out5, ram_addr5, ram_data5, filt_code5, filt_src5, filt_dst5, filt_len5;
  logic [3:0] filt_md5;
  logic       busy4, done4, err4, code_valid4, ram_wren4, filt_start4;
  logic [7:0] code_count4, code_out4, ram_addr4, ram_data4, filt_code4, filt_src4, filt_dst4, filt_len4;
  logic [3:0] filt_md4;

  logic       busy, done, err, code_valid, ram_wren, filt_start;
  logic [7:0] code_count, code_out, ram_addr, ram_data, filt_code, filt_src_base, filt_dst_base, filt_len;
  logic [3:0] filt_min_dist;

  assign busy          = sel ? busy4       : busy5;
  assign done          = sel ? done4       : done5;
  assign err           = sel ? err4        : err5;
  assign code_valid    = sel ? code_valid4 : code_valid5;
  assign ram_wren      = sel ? ram_wren4   : ram_wren5;
  assign filt_start    = sel ? filt_start4 : filt_start5;
  assign code_count    = sel ? code_count4 : code_count5;
  assign code_out      = sel ? code_out4   : code_out5;
  assign ram_addr      = sel ? ram_addr4   : ram_addr5;
  assign ram_data      = sel ? ram_data4   : ram_data5;
  assign filt_code     = sel ? filt_code4  : filt_code5;
  assign filt_src_base = sel ? filt_src4   : filt_src5;
  assign filt_dst_base = sel ? filt_dst4   : filt_dst5;
  assign filt_len      = sel ? filt_len4   : filt_len5;
  assign filt_min_dist = sel ? filt_md4    : filt_md5;

  lexicode_search_ctrl #(.N(5), .START_HOLD(4), .BANK1_BASE(8'h80)) u_dut5 (
    .clock(clock), .reset_n(reset_n), .start(start5), .min_dist(min_dist), .max_codes(max_codes),
    .busy(busy5), .done(done5), .err(err5), .code_count(code_count5), .code_out(code_out5),
    .code_valid(code_valid5), .ram_addr(ram_addr5), .ram_data(ram_data5), .ram_wren(ram_wren5),
    .ram_q(ram_q), .filt_start(filt_start5), .filt_complete(filt_complete), .filt_code(filt_code5),
    .filt_src_base(filt_src5), .filt_dst_base(filt_dst5), .filt_len(filt_len5),
    .filt_min_dist(filt_md5), .filt_next_len(filt_next_len), .filt_addr(filt_addr),
    .filt_data(filt_data), .filt_wren(filt_wren)
  );

  lexicode_search_ctrl #(.N(4), .START_HOLD(4), .BANK1_BASE(8'h80)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .min_dist(min_dist), .max_codes(max_codes),
    .busy(busy4), .done(done4), .err(err4), .code_count(code_count4), .code_out(code_out4),
    .code_valid(code_valid4), .ram_addr(ram_addr4), .ram_data(ram_data4), .ram_wren(ram_wren4),
    .ram_q(ram_q), .filt_start(filt_start4), .filt_complete(filt_complete), .filt_code(filt_code4),
    .filt_src_base(filt_src4), .filt_dst_base(filt_dst4), .filt_len(filt_len4),
    .filt_min_dist(filt_md4), .filt_next_len(filt_next_len), .filt_addr(filt_addr),
    .filt_data(filt_data), .filt_wren(filt_wren)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int got[$];
  int exp_q[$];
  int exp_fs, exp_wren;
  int done_cnt = 0, wren_cnt = 0, fs_cnt = 0;
  bit fs_prev = 1'b0;
  logic [7:0] mem [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Single-port candidate RAM, one cycle read latency
  always @(posedge clock) begin
    if (ram_wren === 1'b1) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  always @(negedge clock) begin
    if (code_valid === 1'b1) got.push_back(int'(code_out));
    if (done === 1'b1) done_cnt++;
    if (ram_wren === 1'b1) wren_cnt++;
    if (filt_start === 1'b1 && !fs_prev) fs_cnt++;
    fs_prev = (filt_start === 1'b1);
  end

  // Candidate filter: copies source entries at distance >= threshold from the code
  initial begin : filt_model
    logic [7:0] fcode, fsrc, fdst, flen, val, k;
    logic [3:0] fmd;
    bit         aborted;
    filt_complete = 1'b0;
    filt_next_len = '0;
    filt_addr     = '0;
    filt_data     = '0;
    filt_wren     = 1'b0;
    forever begin
      @(posedge clock);
      if (filt_start === 1'b1 && reset_n === 1'b1) begin
        #1;
        filt_complete = 1'b0;
        fcode = filt_code; fsrc = filt_src_base; fdst = filt_dst_base;
        flen = filt_len; fmd = filt_min_dist;
        if (got.size() > 0) check("filt_code", 32'(fcode), 32'(got[got.size()-1]));
        check("filt_dst_base", 32'(fdst), 32'(fsrc ^ 8'h80));
        aborted = 1'b0;
        k = '0;
        repeat (2) @(posedge clock);
        for (int i = 0; i < int'(flen) && !aborted; i++) begin
          #1 filt_addr = fsrc + 8'(i);
          filt_wren = 1'b0;
          @(posedge clock);
          #1 val = ram_q;
          if ($countones(val ^ fcode) >= int'(fmd)) begin
            filt_addr = fdst + k;
            filt_data = val;
            filt_wren = 1'b1;
            @(posedge clock);
            #1 filt_wren = 1'b0;
            k = k + 8'd1;
          end
          if (reset_n !== 1'b1) aborted = 1'b1;
        end
        filt_wren = 1'b0;
        if (!aborted) begin
          filt_next_len = k;
          filt_complete = 1'b1;
        end
        while (filt_start === 1'b1) @(posedge clock);
      end
    end
  end

  // Greedy lexicode straight from its definition, plus the expected filter activity
  task automatic build_ref(input int n, input int md, input int mc);
    bit ok;
    exp_q.delete();
    for (int w = 0; w < (1 << n); w++) begin
      ok = 1'b1;
      foreach (exp_q[j]) if ($countones(w ^ exp_q[j]) < md) ok = 1'b0;
      if (ok && (mc == 0 || exp_q.size() < mc)) exp_q.push_back(w);
    end
    exp_fs = (mc != 0 && exp_q.size() == mc) ? exp_q.size() - 1 : exp_q.size();
    exp_wren = 1 << n;
    for (int r = 1; r <= exp_fs; r++) begin
      for (int w = 0; w < (1 << n); w++) begin
        ok = 1'b1;
        for (int j = 0; j < r; j++) if ($countones(w ^ exp_q[j]) < md) ok = 1'b0;
        if (ok) exp_wren++;
      end
    end
  endtask

  task automatic pulse_start(input bit s, input int md, input int mc);
    @(posedge clock);
    #1;
    min_dist = 4'(md);
    max_codes = 8'(mc);
    if (s) start4 = 1'b1; else start5 = 1'b1;
    @(posedge clock);
    #1;
    start4 = 1'b0;
    start5 = 1'b0;
    min_dist = 4'($urandom);
    max_codes = 8'($urandom);
  endtask

  task automatic run_search(input bit s, input int md, input int mc, input bit poke);
    int cyc;
    sel = s;
    build_ref(s ? 4 : 5, md, mc);
    got.delete();
    done_cnt = 0; wren_cnt = 0; fs_cnt = 0;
    pulse_start(s, md, mc);
    check("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (poke && cyc == 40) begin
        min_dist = 4'd0;
        if (s) start4 = 1'b1; else start5 = 1'b1;
      end
      if (poke && cyc == 41) begin
        start4 = 1'b0;
        start5 = 1'b0;
      end
    end
    check("done_before_timeout", 32'(cyc < 20000), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    check("num_codes", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("code[%0d]", i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
    check("code_count", 32'(code_count), 32'(exp_q.size()));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("filter_starts", 32'(fs_cnt), 32'(exp_fs));
    check("ram_writes", 32'(wren_cnt), 32'(exp_wren));
    check("err_clear", 32'(err), 32'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_err"}, 32'(err), 32'd0);
    check({pfx, "_code_count"}, 32'(code_count), 32'd0);
    check({pfx, "_code_out"}, 32'(code_out), 32'd0);
    check({pfx, "_code_valid"}, 32'(code_valid), 32'd0);
    check({pfx, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({pfx, "_ram_data"}, 32'(ram_data), 32'd0);
    check({pfx, "_ram_wren"}, 32'(ram_wren), 32'd0);
    check({pfx, "_filt_start"}, 32'(filt_start), 32'd0);
    check({pfx, "_filt_code"}, 32'(filt_code), 32'd0);
    check({pfx, "_filt_src"}, 32'(filt_src_base), 32'd0);
    check({pfx, "_filt_dst"}, 32'(filt_dst_base), 32'd0);
    check({pfx, "_filt_len"}, 32'(filt_len), 32'd0);
    check({pfx, "_filt_md"}, 32'(filt_min_dist), 32'd0);
  endtask

  initial begin
    int cyc;
    int md, mc;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    sel = 1'b1;
    #1;
    check("reset_n4_busy", 32'(busy), 32'd0);
    check("reset_n4_filt_start", 32'(filt_start), 32'd0);
    sel = 1'b0;
    reset_n = 1'b1;

    // Directed scenarios
    run_search(1'b0, 1, 0, 1'b1);
    run_search(1'b0, 3, 0, 1'b0);
    run_search(1'b1, 2, 0, 1'b0);
    run_search(1'b0, 1, 2, 1'b0);

    // Zero distance request
    sel = 1'b0;
    got.delete();
    done_cnt = 0; wren_cnt = 0; fs_cnt = 0;
    pulse_start(1'b0, 0, 0);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3) begin
      @(negedge clock);
      cyc++;
    end
    check("err_done_within_3", 32'(done_cnt), 32'd1);
    check("err_flag", 32'(err), 32'd1);
    check("err_code_count", 32'(code_count), 32'd0);
    repeat (5) @(negedge clock);
    check("err_held", 32'(err), 32'd1);
    check("err_no_ram_wren", 32'(wren_cnt), 32'd0);
    check("err_single_done", 32'(done_cnt), 32'd1);
    check("err_no_codes", 32'(got.size()), 32'd0);
    run_search(1'b0, 2, 0, 1'b0);

    // Reset while the filter is running
    sel = 1'b0;
    got.delete();
    done_cnt = 0; wren_cnt = 0; fs_cnt = 0;
    pulse_start(1'b0, 3, 0);
    cyc = 0;
    while (cyc < 5000) begin
      @(negedge clock);
      cyc++;
      if (fs_cnt == 2 && filt_start === 1'b0) break;
    end
    check("reached_fwait", 32'(cyc < 5000), 32'd1);
    check("codes_before_reset", 32'(got.size()), 32'd2);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_all_zero("midreset");
    repeat (6) @(posedge clock);
    #1 reset_n = 1'b1;
    run_search(1'b0, 3, 0, 1'b0);

    // Randomized searches on both widths
    for (int r = 0; r < 6; r++) begin
      md = int'($urandom_range(1, 5));
      mc = (r % 3 == 0) ? 0 : int'($urandom_range(1, 6));
      run_search(1'(r % 2), md, mc, r == 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
